// File: rtl/rmt_phv_pkg.sv
// ============================================================================
//  Module      : rmt_phv_pkg
//  Description : PHV layout constants, container widths and the FSM encoding
//                shared by the key extractor and the field deparser.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rmt_phv_pkg;

    localparam int KEY_LEN     = 896;
    localparam int PHV_LEN     = 1579;
    localparam int HDR_OFF     = 555;
    localparam int CONT_OFF_8B = 356;
    localparam int CONT_OFF_4B = 420;
    localparam int CONT_OFF_2B = 484;
    localparam int NUM_CONT    = 24;

    // The three offset banks are contiguous, 8B bank lowest.
    localparam int OFFS_LEN    = 3 * 8 * 8;

    localparam logic [6:0] W_2B = 7'd16;
    localparam logic [6:0] W_4B = 7'd32;
    localparam logic [6:0] W_8B = 7'd64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_OUT   = 2'd2
    } phv_state_e;

endpackage

`default_nettype wire

// File: rtl/container_sel.sv
// ============================================================================
//  Module      : container_sel
//  Description : Maps a container index to its width, header offset and value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module container_sel
    import rmt_phv_pkg::*;
(
    input  logic [4:0]          idx_i,
    input  logic [KEY_LEN-1:0]  field_vals_i,
    input  logic [OFFS_LEN-1:0] offsets_i,
    output logic [6:0]          width_o,
    output logic [7:0]          off_o,
    output logic [63:0]         val_o
);

    logic [15:0] w_v2 [8];
    logic [31:0] w_v4 [8];
    logic [63:0] w_v8 [8];
    logic [7:0]  w_o2 [8];
    logic [7:0]  w_o4 [8];
    logic [7:0]  w_o8 [8];
    logic [2:0]  w_sub;

    // Values are packed with 2B[0] at the MSBs; offsets with entry 0 at the LSBs.
    for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
        assign w_v2[gi] = field_vals_i[KEY_LEN-1-16*gi -: 16];
        assign w_v4[gi] = field_vals_i[KEY_LEN-129-32*gi -: 32];
        assign w_v8[gi] = field_vals_i[KEY_LEN-385-64*gi -: 64];
        assign w_o8[gi] = offsets_i[8*gi +: 8];
        assign w_o4[gi] = offsets_i[(CONT_OFF_4B-CONT_OFF_8B)+8*gi +: 8];
        assign w_o2[gi] = offsets_i[(CONT_OFF_2B-CONT_OFF_8B)+8*gi +: 8];
    end

    assign w_sub = idx_i[2:0];

    always_comb begin
        width_o = W_8B;
        off_o   = w_o8[w_sub];
        val_o   = w_v8[w_sub];
        case (idx_i[4:3])
            2'd0: begin
                width_o = W_2B;
                off_o   = w_o2[w_sub];
                val_o   = {48'd0, w_v2[w_sub]};
            end
            2'd1: begin
                width_o = W_4B;
                off_o   = w_o4[w_sub];
                val_o   = {32'd0, w_v4[w_sub]};
            end
            default: begin
                width_o = W_8B;
                off_o   = w_o8[w_sub];
                val_o   = w_v8[w_sub];
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/field_deparser.sv
// ============================================================================
//  Module      : field_deparser
//  Description : Writes up to 24 modified containers back into the PHV header,
//                one container per cycle, then presents the rewritten PHV.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module field_deparser
    import rmt_phv_pkg::*;
(
    input  logic                axis_clk,
    input  logic                areset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PHV_LEN-1:0]  pkt_hdr_vec_in,
    input  logic [KEY_LEN-1:0]  field_vals,
    input  logic [23:0]         wr_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PHV_LEN-1:0]  pkt_hdr_vec_out,
    output logic                dep_err
);

    phv_state_e         state_q, state_d;
    logic [4:0]         idx_q, idx_d;
    logic [PHV_LEN-1:0] phv_q, phv_d;
    logic [KEY_LEN-1:0] vals_q, vals_d;
    logic [23:0]        wren_q, wren_d;
    logic               err_q, err_d;
    logic               out_valid_q, out_valid_d;
    logic [PHV_LEN-1:0] out_phv_q, out_phv_d;
    logic               out_err_q, out_err_d;

    logic [6:0]         w_width;
    logic [7:0]         w_off;
    logic [63:0]        w_val;
    logic [10:0]        w_base;
    logic               w_in_range;

    container_sel u_sel (
        .idx_i        (idx_q),
        .field_vals_i (vals_q),
        .offsets_i    (phv_q[CONT_OFF_8B +: OFFS_LEN]),
        .width_o      (w_width),
        .off_o        (w_off),
        .val_o        (w_val)
    );

    // The field's MSB sits at header bit 'off'; it spans downward W bits.
    assign w_base     = 11'(HDR_OFF) + {3'b000, w_off};
    assign w_in_range = (w_off >= {1'b0, w_width - 7'd1});

    always_ff @(posedge axis_clk) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 5'd0;
            phv_q       <= '0;
            vals_q      <= '0;
            wren_q      <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_phv_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            phv_q       <= phv_d;
            vals_q      <= vals_d;
            wren_q      <= wren_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_phv_q   <= out_phv_d;
            out_err_q   <= out_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        phv_d       = phv_q;
        vals_d      = vals_q;
        wren_d      = wren_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_phv_d   = out_phv_q;
        out_err_d   = out_err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    phv_d   = pkt_hdr_vec_in;
                    vals_d  = field_vals;
                    wren_d  = wr_en;
                    err_d   = 1'b0;
                    idx_d   = 5'd0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wren_q[idx_q]) begin
                    if (w_in_range) begin
                        case (w_width)
                            W_2B:    phv_d[w_base -: 16] = w_val[15:0];
                            W_4B:    phv_d[w_base -: 32] = w_val[31:0];
                            default: phv_d[w_base -: 64] = w_val;
                        endcase
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (idx_q == 5'(NUM_CONT - 1)) begin
                    idx_d   = 5'd0;
                    state_d = ST_OUT;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            ST_OUT: begin
                // First OUT cycle loads the output register; later cycles wait for the handshake.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_phv_d   = phv_q;
                    out_err_d   = err_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready        = (state_q == ST_IDLE) && !areset;
    assign out_valid       = out_valid_q;
    assign pkt_hdr_vec_out = out_phv_q;
    assign dep_err         = out_err_q;

endmodule

`default_nettype wire

// File: tb/tb_field_deparser.sv
// ============================================================================
//  Module      : tb_field_deparser
//  Description : Scoreboard bench for field_deparser with a bit-level PHV model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_field_deparser;

    localparam int KEY_LEN = 896;
    localparam int PHV_LEN = 1579;
    localparam int HDR_OFF = 555;
    localparam int OFF_8B  = 356;
    localparam int OFF_4B  = 420;
    localparam int OFF_2B  = 484;

    logic               axis_clk = 1'b0;
    logic               areset = 1'b1;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b1;
    logic               in_ready, out_valid, dep_err;
    logic [PHV_LEN-1:0] pkt_hdr_vec_in = '0;
    logic [PHV_LEN-1:0] pkt_hdr_vec_out;
    logic [KEY_LEN-1:0] field_vals = '0;
    logic [23:0]        wr_en = '0;

    typedef struct {
        logic [PHV_LEN-1:0] phv;
        logic               err;
    } exp_t;

    exp_t               sb[$];
    exp_t               mx;
    int                 n_tests = 0;
    int                 n_fail = 0;
    logic [PHV_LEN-1:0] cur_phv;
    logic [KEY_LEN-1:0] cur_vals;
    logic [23:0]        cur_en;
    logic [PHV_LEN-1:0] last_exp;

    field_deparser dut (
        .axis_clk        (axis_clk),
        .areset          (areset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .pkt_hdr_vec_in  (pkt_hdr_vec_in),
        .field_vals      (field_vals),
        .wr_en           (wr_en),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .pkt_hdr_vec_out (pkt_hdr_vec_out),
        .dep_err         (dep_err)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic check(input string tag, input logic [PHV_LEN-1:0] got,
                         input logic [PHV_LEN-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            int d, s;
            d = 0;
            for (int i = PHV_LEN - 1; i >= 0; i--)
                if (got[i] !== exp[i]) d = i;
            s = (d / 64) * 64;
            if (s > PHV_LEN - 64) s = PHV_LEN - 64;
            n_fail++;
            $display("FAIL %s: got[%0d+:64]=%h expected %h (first differing bit %0d)",
                     tag, s, got[s +: 64], exp[s +: 64], d);
        end
    endtask

    function automatic int cw(input int k);
        return (k < 8) ? 16 : (k < 16) ? 32 : 64;
    endfunction

    function automatic int vlsb(input int k);
        if (k < 8)  return 768 + 16 * (7 - k);
        if (k < 16) return 512 + 32 * (15 - k);
        return 64 * (23 - k);
    endfunction

    function automatic int olsb(input int k);
        if (k < 8)  return OFF_2B + 8 * k;
        if (k < 16) return OFF_4B + 8 * (k - 8);
        return OFF_8B + 8 * (k - 16);
    endfunction

    function automatic void model(input logic [PHV_LEN-1:0] p, input logic [KEY_LEN-1:0] v,
                                  input logic [23:0] en,
                                  output logic [PHV_LEN-1:0] e, output logic err);
        e   = p;
        err = 1'b0;
        for (int k = 0; k < 24; k++) begin
            int w, off, vl;
            w   = cw(k);
            vl  = vlsb(k);
            off = int'(p[olsb(k) +: 8]);
            if (en[k]) begin
                if (off >= w - 1) begin
                    for (int b = 0; b < w; b++)
                        e[HDR_OFF + off - (w - 1) + b] = v[vl + b];
                end else begin
                    err = 1'b1;
                end
            end
        end
    endfunction

    task automatic rand_pkt();
        for (int i = 0; i < PHV_LEN; i++) cur_phv[i] = 1'($urandom);
        for (int i = 0; i < KEY_LEN; i++) cur_vals[i] = 1'($urandom);
        cur_en = '0;
    endtask

    task automatic set_off(input int k, input int off);
        cur_phv[olsb(k) +: 8] = 8'(off);
    endtask

    task automatic set_val(input int k, input logic [63:0] v);
        for (int b = 0; b < cw(k); b++) cur_vals[vlsb(k) + b] = v[b];
    endtask

    task automatic send();
        exp_t x;
        int   cnt;
        model(cur_phv, cur_vals, cur_en, x.phv, x.err);
        last_exp = x.phv;
        @(posedge axis_clk);
        #1;
        in_valid       = 1'b1;
        pkt_hdr_vec_in = cur_phv;
        field_vals     = cur_vals;
        wr_en          = cur_en;
        cnt = 0;
        while (!in_ready && cnt < 200) begin
            @(posedge axis_clk);
            #1;
            cnt++;
        end
        check("accept_ready", in_ready, 1);
        if (in_ready) sb.push_back(x);
        @(posedge axis_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge axis_clk);
            lat++;
        end while (!out_valid && lat < 100);
    endtask

    always @(negedge axis_clk) begin
        if (!areset && out_valid && out_ready) begin
            check("sb_pending", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                mx = sb.pop_front();
                check("out_phv", pkt_hdr_vec_out, mx.phv);
                check("out_err", dep_err, mx.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int                 lat;
        logic               seen;
        logic [PHV_LEN-1:0] refp;

        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_phv", pkt_hdr_vec_out, '0);
        check("rst_dep_err", dep_err, 0);
        @(posedge axis_clk);
        #1 areset = 1'b0;
        @(negedge axis_clk);
        check("ready_after_rst", in_ready, 1);

        // Single 2B write at offset 15
        rand_pkt();
        set_off(0, 15);
        set_val(0, 64'hBEEF);
        cur_en = 24'h000001;
        refp = cur_phv;
        refp[HDR_OFF +: 16] = 16'hBEEF;
        send();
        wait_out(lat);
        check("lat_single", lat, 26);
        check("single_beef", pkt_hdr_vec_out[HDR_OFF +: 16], 16'hBEEF);
        check("single_rest", pkt_hdr_vec_out, refp);
        check("single_err", dep_err, 0);

        // All disabled: exact pass-through
        rand_pkt();
        refp = cur_phv;
        send();
        wait_out(lat);
        check("lat_none", lat, 26);
        check("passthru", pkt_hdr_vec_out, refp);
        check("passthru_err", dep_err, 0);

        // Overlap: 8B[0] overrides 2B[3] at the same offset
        rand_pkt();
        set_off(3, 63);
        set_val(3, 64'h1111);
        set_off(16, 63);
        set_val(16, {8{8'hAA}});
        cur_en = 24'h010008;
        send();
        wait_out(lat);
        check("overlap", pkt_hdr_vec_out[HDR_OFF +: 64], {8{8'hAA}});
        check("overlap_err", dep_err, 0);

        // Out-of-range 4B write, then a clean packet
        rand_pkt();
        set_off(10, 20);
        set_val(10, 64'h12345678);
        cur_en = 24'h000400;
        refp = cur_phv;
        send();
        wait_out(lat);
        check("oor_hdr", pkt_hdr_vec_out, refp);
        check("oor_err", dep_err, 1);

        rand_pkt();
        set_off(10, 40);
        cur_en = 24'h000400;
        send();
        wait_out(lat);
        check("clean_err", dep_err, 0);

        // Random packets, mixed enables and offsets
        for (int n = 0; n < 6; n++) begin
            rand_pkt();
            cur_en = 24'($urandom);
            send();
            wait_out(lat);
            check("lat_rand", lat, 26);
        end

        // Back-pressure: output must hold for 10 cycles
        @(posedge axis_clk);
        #1 out_ready = 1'b0;
        rand_pkt();
        cur_en = 24'($urandom);
        send();
        wait_out(lat);
        check("lat_bp", lat, 26);
        repeat (10) begin
            @(negedge axis_clk);
            check("bp_valid", out_valid, 1);
            check("bp_data", pkt_hdr_vec_out, last_exp);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge axis_clk);
        #1 out_ready = 1'b1;

        // Reset while idx 12 is being written drops the packet
        rand_pkt();
        cur_en = 24'hFFFFFF;
        send();
        repeat (12) @(posedge axis_clk);
        #1 areset = 1'b1;
        if (sb.size() != 0) void'(sb.pop_back());
        @(negedge axis_clk);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        @(posedge axis_clk);
        #1 areset = 1'b0;
        @(negedge axis_clk);
        check("release_in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (30) begin
            @(negedge axis_clk);
            if (out_valid) seen = 1'b1;
        end
        check("no_out_after_rst", seen, 0);

        rand_pkt();
        cur_en = 24'($urandom);
        send();
        wait_out(lat);
        check("lat_after_rst", lat, 26);

        repeat (5) @(negedge axis_clk);
        check("sb_drained", sb.size() == 0, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/field_deparser.md
# field_deparser

Write-back counterpart of the stage key extractor. It accepts a PHV plus 24 modified container values (8×2B, 8×4B, 8×8B, packed in key order) from the action stage. It deposits each enabled value into the 1024-bit packet header at the offset stored in the PHV, then emits the rewritten PHV to the next stage or deparser output through a valid/ready handshake.

## Interface
- `KEY_LEN`, 896: packed container-value width (8·16 + 8·32 + 8·64).
- `PHV_LEN`, 1579: PHV width (1024 + 7 + 24·8 + 5·20 + 256).
- `HDR_OFF`, 555: LSB of the packet-header region in the PHV.
- `CONT_OFF_8B`, 356: LSB of the eight 8B offsets.
- `CONT_OFF_4B`, 420: LSB of the eight 4B offsets.
- `CONT_OFF_2B`, 484: LSB of the eight 2B offsets.
- `axis_clk` in 1: sole clock.
- `areset` in 1: synchronous, active-high reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block can accept a beat.
- `pkt_hdr_vec_in` in PHV_LEN: PHV carrying the header and offsets.
- `field_vals` in KEY_LEN: container values, packed as {2B[0..7], 4B[0..7], 8B[0..7]} with 2B[0] at the MSBs.
- `wr_en` in 24: per-container write enable. Bit k selects container k; k=0–7 are 2B, 8–15 are 4B, 16–23 are 8B.
- `out_valid` out 1: rewritten PHV valid.
- `out_ready` in 1: downstream accepts.
- `pkt_hdr_vec_out` out PHV_LEN: PHV with the header region rewritten. All other bits equal the input.
- `dep_err` out 1: at least one enabled write was out of range. Qualified by `out_valid`.

## Operation
- FSM states are IDLE, WRITE, OUT.
- IDLE: `in_ready`=1.
  - On `in_valid`, latch the PHV, `field_vals` and `wr_en`.
  - Clear the error flag, set idx=0, go to WRITE.
- WRITE: process one container per cycle, in idx order 0..23.
  - Width W = 16/32/64 by group. Offset `off` = 8-bit field for that container.
  - If `wr_en[idx]` and `off` ≥ W−1: header[off -: W] ← value.
  - If `wr_en[idx]` and `off` < W−1: no write; set the error flag.
  - Disabled containers still consume their cycle.
  - After idx=23, go to OUT.
- Overlapping fields: later idx wins. 8B overwrites 4B, which overwrites 2B; within a group the higher index wins.
- OUT: `out_valid`=1 with output stable until `out_ready`. On the handshake, go to IDLE.
- Offsets, `header_len` (bits HDR_OFF−1 -: 7), condition and metadata bits pass through unchanged.
- Header bit indexing is relative to `pkt_hdr_vec[HDR_OFF]`, matching the extractor's `-:` convention. A value read back by the extractor at the same offset returns the written value.

## Timing
- Reset values:
  - state IDLE, idx 0.
  - `out_valid`=0, `pkt_hdr_vec_out`=0, `dep_err`=0.
  - `in_ready`=0 while `areset` is high, 1 on the first cycle after release.
- Latency: accept on edge T. Writes occur on edges T+1..T+24. `out_valid` rises after edge T+25, regardless of `wr_en`.
- Handshake:
  - Input transfers on `in_valid && in_ready`.
  - Output transfers on `out_valid && out_ready`.
  - `in_ready` is 0 in WRITE and OUT, so there is no overlap; throughput is one PHV per ≥26 cycles.
- Back-pressure: OUT holds indefinitely. `out_ready` asserted while not `out_valid` has no effect.
- The cycle after the output handshake is IDLE. A new beat may be accepted that cycle.
- `areset` mid-packet drops the packet: no output, state returns to IDLE.

## Structure
- Shared package `rmt_phv_pkg` holds:
  - PHV_LEN, KEY_LEN, HDR_OFF, CONT_OFF_* and the width constants 16/32/64.
  - FSM state encoding, shared with `key_extract`.
- Sub-module `container_sel`: combinational; idx → {width, offset, value}. The top level owns the FSM, header register and write logic.

## Test plan
- Single write: 2B[0]=16'hBEEF, off 2B[0]=15, `wr_en`=24'h000001 → header[15:0]=BEEF; all other PHV bits unchanged; `out_valid` at T+25; `dep_err`=0.
- All disabled: `wr_en`=0, random PHV → `pkt_hdr_vec_out` == input exactly.
- Overlap: 2B[3]=16'h1111 and 8B[0]=64'hAAAA…AA both at off 63, both enabled → header[63:0]=all AA.
- Out of range: 4B[2] off=20, enabled → header unchanged in that field; `dep_err`=1. A following clean packet reports `dep_err`=0.
- Back-pressure and reset: `out_ready` held low 10 cycles → output stable, `in_ready`=0. Then assert `areset` at idx=12 of the next packet → no `out_valid`; `in_ready`=1 after release; the next packet completes normally.
